// File: rtl/matmul_compute_ctrl.sv
// matmul_compute_ctrl
//   Sequencer for the matrix-multiply datapath. Once the A (M x K) and B (K x N)
//   input memories report matrices_loaded, it walks every output element (m,n)
//   with k innermost, issuing one A/B read-address pair per cycle, and produces
//   MAC enable/clear strobes aligned to the 1-cycle memory read latency, a
//   result strobe per finished element, and a compute_finished pulse that
//   releases the input memories.
//
// Ports
//   clk              : clock, all logic on posedge
//   reset            : synchronous, active-high
//   matrices_loaded  : A and B valid in memory; held until after compute_finished
//   K                : shared dimension, latched at run start
//   out_ready        : downstream can take one more result; sampled at k=0 only
//   A_read_addr      : registered A address, m*K + k
//   B_read_addr      : registered B address, k*N + n
//   mac_en           : memory data this cycle is a valid product term
//   mac_clr          : with mac_en, first term of a dot product (load, not add)
//   result_valid     : accumulator holds a finished element (1-cycle pulse)
//   out_row/out_col  : (m,n) of the finished element, valid with result_valid
//   compute_finished : 1-cycle pulse the cycle after the last result_valid
module matmul_compute_ctrl #(
  parameter int M    = 7,
  parameter int N    = 9,
  parameter int MAXK = 8,
  localparam int K_BITS      = $clog2(MAXK + 1),
  localparam int A_ADDR_BITS = $clog2(M * MAXK),
  localparam int B_ADDR_BITS = $clog2(MAXK * N),
  localparam int ROW_W       = $clog2(M),
  localparam int COL_W       = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   matrices_loaded,
  input  logic [K_BITS-1:0]      K,
  input  logic                   out_ready,
  output logic [A_ADDR_BITS-1:0] A_read_addr,
  output logic [B_ADDR_BITS-1:0] B_read_addr,
  output logic                   mac_en,
  output logic                   mac_clr,
  output logic                   result_valid,
  output logic [ROW_W-1:0]       out_row,
  output logic [COL_W-1:0]       out_col,
  output logic                   compute_finished
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t state, next_state;

  logic                   armed;
  logic [K_BITS-1:0]      k_len;
  logic [K_BITS-1:0]      k_sel;
  logic [K_BITS-1:0]      k_cnt;
  logic [COL_W-1:0]       n_cnt;
  logic [ROW_W-1:0]       m_cnt;
  // m*k_len for the current row, so the A address is rebuilt without a multiply
  logic [A_ADDR_BITS-1:0] row_base;

  logic start;
  logic issue_p0;
  logic last_k;
  logic last_term;

  logic             vld_p1;
  logic             clr_p1;
  logic             last_p1;
  logic [ROW_W-1:0] row_p1;
  logic [COL_W-1:0] col_p1;

  logic             vld_p2;
  logic [ROW_W-1:0] row_p2;
  logic [COL_W-1:0] col_p2;

  // A K larger than the memories can hold is clamped so addresses stay in range.
  assign k_sel     = (K > K_BITS'(MAXK)) ? K_BITS'(MAXK) : K;
  assign last_k    = (k_cnt == k_len - K_BITS'(1));
  assign last_term = last_k && (n_cnt == COL_W'(N - 1)) && (m_cnt == ROW_W'(M - 1));

  assign mac_en           = vld_p1;
  assign mac_clr          = clr_p1;
  assign result_valid     = vld_p2;
  assign out_row          = row_p2;
  assign out_col          = col_p2;
  assign compute_finished = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    issue_p0   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && matrices_loaded) begin
          start      = 1'b1;
          next_state = (K == '0) ? FINISH : ISSUE;
        end
      end
      ISSUE: begin
        // Backpressure only gates the start of an element, never mid-dot-product.
        if ((k_cnt != '0) || out_ready) begin
          issue_p0 = 1'b1;
          if (last_term) begin
            next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (vld_p2 && (row_p2 == ROW_W'(M - 1)) && (col_p2 == COL_W'(N - 1))) begin
          next_state = FINISH;
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Stage p0: counters and registered read addresses for the term being issued
  always_ff @(posedge clk) begin
    if (reset) begin
      armed       <= 1'b1;
      k_len       <= '0;
      k_cnt       <= '0;
      n_cnt       <= '0;
      m_cnt       <= '0;
      row_base    <= '0;
      A_read_addr <= '0;
      B_read_addr <= '0;
    end else begin
      // Re-arm only after the memories have dropped matrices_loaded, so one
      // load yields exactly one run.
      if ((state == IDLE) && !matrices_loaded) begin
        armed <= 1'b1;
      end
      if (start) begin
        armed       <= 1'b0;
        k_len       <= k_sel;
        k_cnt       <= '0;
        n_cnt       <= '0;
        m_cnt       <= '0;
        row_base    <= '0;
        A_read_addr <= '0;
        B_read_addr <= '0;
      end else if (issue_p0) begin
        if (!last_k) begin
          k_cnt       <= k_cnt + K_BITS'(1);
          A_read_addr <= A_read_addr + A_ADDR_BITS'(1);
          B_read_addr <= B_read_addr + B_ADDR_BITS'(N);
        end else begin
          k_cnt <= '0;
          if (n_cnt != COL_W'(N - 1)) begin
            n_cnt       <= n_cnt + COL_W'(1);
            A_read_addr <= row_base;
            B_read_addr <= B_ADDR_BITS'(n_cnt) + B_ADDR_BITS'(1);
          end else begin
            n_cnt       <= '0;
            B_read_addr <= '0;
            if (m_cnt != ROW_W'(M - 1)) begin
              m_cnt       <= m_cnt + ROW_W'(1);
              row_base    <= row_base + A_ADDR_BITS'(k_len);
              A_read_addr <= row_base + A_ADDR_BITS'(k_len);
            end else begin
              // Run complete: park the addresses at 0 rather than one past the end.
              m_cnt       <= '0;
              row_base    <= '0;
              A_read_addr <= '0;
            end
          end
        end
      end
    end
  end

  // Stage p1: memory data present, MAC enable/clear for the issued term
  // Stage p2: accumulator holds the finished element
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      clr_p1  <= 1'b0;
      last_p1 <= 1'b0;
      row_p1  <= '0;
      col_p1  <= '0;
      vld_p2  <= 1'b0;
      row_p2  <= '0;
      col_p2  <= '0;
    end else begin
      vld_p1  <= issue_p0;
      clr_p1  <= issue_p0 && (k_cnt == '0);
      last_p1 <= issue_p0 && last_k;
      row_p1  <= m_cnt;
      col_p1  <= n_cnt;
      vld_p2  <= vld_p1 && last_p1;
      row_p2  <= row_p1;
      col_p2  <= col_p1;
    end
  end

endmodule

// File: tb/tb_matmul_compute_ctrl.sv
// Scoreboard bench for matmul_compute_ctrl: each run pushes the expected
// product terms and results computed from plain (m,n,k) loops; a negedge
// monitor pops and compares whenever the DUT raises mac_en / result_valid /
// compute_finished.
module tb_matmul_compute_ctrl;

  localparam int M      = 7;
  localparam int N      = 9;
  localparam int MAXK   = 8;
  localparam int K_BITS = $clog2(MAXK + 1);
  localparam int A_W    = $clog2(M * MAXK);
  localparam int B_W    = $clog2(MAXK * N);
  localparam int R_W    = $clog2(M);
  localparam int C_W    = $clog2(N);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              matrices_loaded = 1'b0;
  logic [K_BITS-1:0] K = '0;
  logic              out_ready = 1'b1;
  logic [A_W-1:0]    A_read_addr;
  logic [B_W-1:0]    B_read_addr;
  logic              mac_en;
  logic              mac_clr;
  logic              result_valid;
  logic [R_W-1:0]    out_row;
  logic [C_W-1:0]    out_col;
  logic              compute_finished;

  matmul_compute_ctrl #(.M(M), .N(N), .MAXK(MAXK)) dut (
    .clk              (clk),
    .reset            (reset),
    .matrices_loaded  (matrices_loaded),
    .K                (K),
    .out_ready        (out_ready),
    .A_read_addr      (A_read_addr),
    .B_read_addr      (B_read_addr),
    .mac_en           (mac_en),
    .mac_clr          (mac_clr),
    .result_valid     (result_valid),
    .out_row          (out_row),
    .out_col          (out_col),
    .compute_finished (compute_finished)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a; int b; int m; int n; int k; bit clr; bit last;
  } term_t;
  typedef struct {
    int m; int n;
  } res_t;

  term_t term_q[$];
  res_t  res_q[$];
  term_t mt;
  res_t  mr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_fin = 0;
  int fin_count = 0;
  int fin_cyc = 0;
  int f0 = 0;
  int mac_cnt = 0;
  int res_cnt = 0;
  int gap = 0;
  int last_gap = 0;
  int gap_m = -1;
  int gap_n = -1;
  int t0 = 0;
  int prev_a = 0;
  int prev_b = 0;
  bit in_dot = 1'b0;
  bit last_prev = 1'b0;
  bit this_last = 1'b0;
  bit rand_mode = 1'b0;
  int stall_lo = 0;
  int stall_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // out_ready driver: random backpressure, or a fixed low window [stall_lo, stall_hi)
  always @(posedge clk) begin
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    else           out_ready = !((cyc >= stall_lo) && (cyc < stall_hi));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string p);
    chk({p, "_A_addr"}, int'(A_read_addr), 0);
    chk({p, "_B_addr"}, int'(B_read_addr), 0);
    chk({p, "_mac_en"}, int'(mac_en), 0);
    chk({p, "_mac_clr"}, int'(mac_clr), 0);
    chk({p, "_result_valid"}, int'(result_valid), 0);
    chk({p, "_out_row"}, int'(out_row), 0);
    chk({p, "_out_col"}, int'(out_col), 0);
    chk({p, "_finished"}, int'(compute_finished), 0);
  endtask

  // Reference model: every dot product in row-major (m,n) order, k innermost.
  task automatic push_model(input int k);
    term_t t;
    res_t  r;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        for (int kk = 0; kk < k; kk++) begin
          t.a = m * k + kk;  t.b = kk * N + n;
          t.m = m; t.n = n; t.k = kk;
          t.clr = (kk == 0); t.last = (kk == k - 1);
          term_q.push_back(t);
        end
        if (k > 0) begin
          r.m = m; r.n = n;
          res_q.push_back(r);
        end
      end
    end
    exp_fin++;
  endtask

  // Monitor
  always @(negedge clk) begin
    this_last = 1'b0;
    if (reset) begin
      in_dot = 1'b0;
      last_prev = 1'b0;
      gap = 0;
    end else begin
      if (mac_clr && !mac_en) begin
        checks++; errors++;
        $display("FAIL mac_clr_alone: got mac_clr=1 with mac_en=0 (cycle %0d)", cyc);
      end
      if (mac_en) begin
        mac_cnt++;
        checks++;
        if (term_q.size() == 0) begin
          errors++;
          $display("FAIL mac_unexpected: got mac_en=1 A=%0d B=%0d, expected no term (cycle %0d)",
                   prev_a, prev_b, cyc);
        end else begin
          mt = term_q.pop_front();
          if (prev_a != mt.a || prev_b != mt.b || int'(mac_clr) != int'(mt.clr)) begin
            errors++;
            $display("FAIL mac_term m=%0d n=%0d k=%0d: got A=%0d B=%0d clr=%0d, expected A=%0d B=%0d clr=%0d (cycle %0d)",
                     mt.m, mt.n, mt.k, prev_a, prev_b, mac_clr, mt.a, mt.b, mt.clr, cyc);
          end
          if (mt.k == 0 && (mt.m != 0 || mt.n != 0) && gap > 0) begin
            last_gap = gap; gap_m = mt.m; gap_n = mt.n;
          end
          this_last = mt.last;
          in_dot = !mt.last;
        end
        gap = 0;
      end else begin
        if (in_dot) begin
          checks++; errors++;
          $display("FAIL gap_in_dot: got mac_en=0 inside a dot product, expected 1 (cycle %0d)", cyc);
          in_dot = 1'b0;
        end
        gap++;
      end
      if (result_valid || last_prev)
        chk("result_align", int'(result_valid), int'(last_prev));
      if (result_valid) begin
        res_cnt++;
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL res_unexpected: got row=%0d col=%0d, expected none", out_row, out_col);
        end else begin
          mr = res_q.pop_front();
          chk("res_row", int'(out_row), mr.m);
          chk("res_col", int'(out_col), mr.n);
        end
      end
      if (compute_finished) begin
        fin_count++;
        fin_cyc = cyc;
        checks++;
        if (exp_fin == 0) begin
          errors++;
          $display("FAIL fin_unexpected: got compute_finished=1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_fin--;
        end
      end
    end
    last_prev = this_last;
    prev_a = int'(A_read_addr);
    prev_b = int'(B_read_addr);
  end

  task automatic start_run(input int k);
    push_model(k);
    mac_cnt = 0; res_cnt = 0;
    last_gap = 0; gap_m = -1; gap_n = -1;
    f0 = fin_count;
    K = K_BITS'(k);
    matrices_loaded = 1'b1;
    t0 = cyc;
  endtask

  task automatic finish_run(input int k, input int exp_len);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (fin_count > f0) break;
      K = K_BITS'($urandom_range(0, MAXK));  // must be ignored mid-run
    end
    if (fin_count == f0) begin
      errors++;
      $display("FAIL finish_timeout: got no compute_finished, expected one (K=%0d)", k);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (exp_len >= 0) chk("fin_time", fin_cyc - t0, exp_len);
    chk("mac_count", mac_cnt, M * N * k);
    chk("res_count", res_cnt, (k > 0) ? M * N : 0);
    chk("terms_left", term_q.size(), 0);
    chk("results_left", res_q.size(), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("no_rerun_mac", mac_cnt, M * N * k);
    chk("no_rerun_fin", fin_count, f0 + 1);
    matrices_loaded = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    int kr;
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Full run, K = MAXK
    start_run(8);
    finish_run(8, 507);

    // K = 1: every term is both first and last
    start_run(1);
    finish_run(1, 66);

    // out_ready low for 5 cycles at the start of element (2,3)
    start_run(8);
    stall_lo = t0 + 1 + (2 * N + 3) * 8;
    stall_hi = stall_lo + 5;
    finish_run(8, 512);
    chk("stall_gap_len", last_gap, 5);
    chk("stall_gap_row", gap_m, 2);
    chk("stall_gap_col", gap_n, 3);
    stall_lo = 0; stall_hi = 0;

    // K = 0: straight to finish
    start_run(0);
    finish_run(0, 1);

    // Re-arm after low, new K takes effect
    start_run(4);
    finish_run(4, 255);

    // Reset in the middle of ISSUE with matrices_loaded still high
    start_run(8);
    repeat (100) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    @(posedge clk); #1;
    term_q.delete();
    res_q.delete();
    exp_fin = 0;
    reset = 1'b0;
    start_run(8);
    finish_run(8, 507);

    // Random K with random backpressure
    rand_mode = 1'b1;
    for (int r = 0; r < 3; r++) begin
      kr = $urandom_range(1, MAXK);
      start_run(kr);
      finish_run(kr, -1);
    end
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/matmul_compute_ctrl.md
# matmul_compute_ctrl

Sequencer for the matrix-multiply datapath. It sits between the input memories (A: M×K, B: K×N) and the MAC/output stage. Once the input memories report `matrices_loaded`, it walks every output element (m,n) and every k, issues read addresses to both memories, and generates MAC enable/clear strobes aligned to the 1-cycle memory read latency. It emits a result strobe per output element and pulses `compute_finished` to release the input memories for the next load.

## Interface
- `M`, 7: rows of A and of the output.
- `N`, 9: columns of B and of the output.
- `MAXK`, 8: maximum shared dimension K.
- Derived (localparam): `K_BITS=$clog2(MAXK+1)`, `A_ADDR_BITS=$clog2(M*MAXK)`, `B_ADDR_BITS=$clog2(MAXK*N)`.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: synchronous, active-high.
- `matrices_loaded` in 1: A and B are valid in memory; stays high until after `compute_finished`.
- `K` in K_BITS: shared dimension, valid while `matrices_loaded`=1.
- `out_ready` in 1: downstream can accept one more result; sampled only at the start of each output element.
- `A_read_addr` out A_ADDR_BITS: A address, equal to m*K+k.
- `B_read_addr` out B_ADDR_BITS: B address, equal to k*N+n.
- `mac_en` out 1: memory data present this cycle is a valid product term.
- `mac_clr` out 1: with `mac_en`, start a new dot product (load instead of accumulate).
- `result_valid` out 1: accumulator holds a finished element, 1-cycle pulse.
- `out_row` out $clog2(M): m of the finished element, valid with `result_valid`.
- `out_col` out $clog2(N): n of the finished element, valid with `result_valid`.
- `compute_finished` out 1: 1-cycle pulse after the last result.

## Operation
- States: IDLE, ISSUE, DRAIN, FINISH.
- Internal `armed` flag: set by reset, cleared on entry to ISSUE, set again when `matrices_loaded`=0 is sampled in IDLE. This stops a second run on the same load.
- **IDLE**:
  - If `armed` and `matrices_loaded`=1: latch K into `k_len` and zero the m/n/k counters.
  - K≠0: go to ISSUE.
  - K=0: go to FINISH. No addresses and no results are produced.
- **ISSUE**, one address pair per cycle; loop order is k innermost, then n, then m:
  - At k=0 with `out_ready`=0: stall, hold counters, issue nothing, so `mac_en` is 0 one cycle later. Stalls never occur mid-dot-product.
  - After issuing (M-1,N-1,k_len-1): go to DRAIN.
- **DRAIN**: held until the final `result_valid` has been emitted, then go to FINISH.
- **FINISH**: `compute_finished`=1 for one cycle, then IDLE.
- Address generation uses running counters/adders, not multipliers:
  - `A_read_addr` = m*k_len + k.
  - `B_read_addr` = k*N + n.
  - Both are always less than M*MAXK and MAXK*N respectively.
- K changing mid-run is ignored; `k_len` is used throughout.
- Reset mid-run: return to IDLE and clear all strobes. A run restarts from (0,0,0) if `matrices_loaded` is still 1 after reset.

## Timing
- Reset values: all outputs 0, including addresses, strobes, `out_row`/`out_col` and `compute_finished`.
- Cycle t0: IDLE samples `matrices_loaded`=1 with `armed`. At t0+1 the first address is on `A_read_addr`/`B_read_addr` (registered outputs).
- Memory read latency is 1 cycle. `mac_en`/`mac_clr` are the issue-cycle flags delayed by 1 cycle, so they coincide with `A_data`/`B_data`.
- `mac_clr`=1 exactly when `mac_en`=1 and the term has k=0.
- `result_valid` is asserted the cycle after the `mac_en` of term k=k_len-1, carrying that element's `out_row`/`out_col`.
- `compute_finished` is asserted the cycle after the last `result_valid`.
- Run length with no stalls: M*N*k_len issue cycles + 2 + 1.
- K=0: `compute_finished` is asserted at t0+1.
- Back-to-back: consecutive output elements issue on consecutive cycles with no bubble while `out_ready`=1.

## Test plan
- Defaults, K=8, `out_ready`=1:
  - Exactly 504 `mac_en` cycles and 63 `result_valid` pulses in row-major (m,n) order.
  - `compute_finished` at t0+507.
  - A address sequence 0..55, each row repeated 9×.
  - B address for (m=0,n=1) is 1,10,19,…,64.
- K=1:
  - Every `mac_en` has `mac_clr`=1.
  - `result_valid` follows each `mac_en` by 1 cycle.
  - 63 results, finish at t0+66.
- `out_ready` dropped for 5 cycles at the start of element (2,3):
  - `mac_en` gap of exactly 5 cycles before k=0 of that element.
  - No gap inside any dot product.
  - Result count is unchanged.
- K=0: no `mac_en`, no `result_valid`; `compute_finished` at t0+1; next cycle IDLE.
- `matrices_loaded` held high for 3 cycles after `compute_finished`, then low, then high with K=4:
  - No second run until the low is seen.
  - The new run uses K=4: A_read_addr for (1,0,2) is 6.
- Reset asserted mid-ISSUE with `matrices_loaded`=1:
  - All outputs are 0 the cycle after reset.
  - After reset release, the run restarts at address pair (0,0).
